// File: rtl/sdcard_pkg.sv
// Shared SD command-line constants, responder state encoding and a reference CRC7.
package sdcard_pkg;

    localparam logic [6:0]  Crc7Poly = 7'h09;
    localparam int unsigned FrameW   = 48;
    localparam int unsigned CrcBodyW = 40;
    localparam int unsigned CrcW     = 7;

    typedef enum logic [2:0] {
        StRxIdle,
        StRxShift,
        StRxCheck,
        StWaitApp,
        StNcrWait,
        StTxShift,
        StTxRelease
    } resp_state_e;

    // CRC7 over frame bits 47:8, MSB first, init 0.
    function automatic logic [CrcW-1:0] crc7(input logic [CrcBodyW-1:0] body);
        logic [CrcW-1:0] crc;
        crc = '0;
        for (int i = CrcBodyW - 1; i >= 0; i--) begin
            crc = {crc[CrcW-2:0], 1'b0} ^ ((body[i] ^ crc[CrcW-1]) ? Crc7Poly : '0);
        end
        return crc;
    endfunction

endpackage

// File: rtl/sdcard_crc7_serial.sv
// Bit-serial CRC7 (x^7+x^3+1). shift_i turns the register into a plain shifter so the
// finished CRC can be streamed out MSB first from crc_o[6].
module sdcard_crc7_serial
    import sdcard_pkg::*;
(
    input  logic            PCLK_i,
    input  logic            PRESETn_i,
    input  logic            clear_i,
    input  logic            enable_i,
    input  logic            shift_i,
    input  logic            data_i,
    output logic [CrcW-1:0] crc_o
);

    logic [CrcW-1:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear_i) begin
            crc_d = '0;
        end else if (enable_i) begin
            if (shift_i) begin
                crc_d = {crc_q[CrcW-2:0], 1'b0};
            end else begin
                crc_d = {crc_q[CrcW-2:0], 1'b0} ^ ((data_i ^ crc_q[CrcW-1]) ? Crc7Poly : '0);
            end
        end
    end

    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sdcard_cmd_responder.sv
// Card-side SD CMD-line responder: receives and checks host frames, returns responses.
// Optional feature macro: SDCARD_CMD_RESP_CRC_INJECT_EN (adds crc_inject_i).
module sdcard_cmd_responder
    import sdcard_pkg::*;
#(
    parameter int unsigned NCR          = 2,
    parameter int unsigned RESP_TIMEOUT = 64
) (
    input  logic        PCLK_i,
    input  logic        PRESETn_i,
    input  logic        bit_en_i,
    input  logic        cmd_in_i,
    output logic        cmd_out_o,
    output logic        cmd_oe_o,
    output logic        cmd_valid_o,
    output logic [5:0]  cmd_index_o,
    output logic [31:0] cmd_arg_o,
    input  logic        resp_valid_i,
    input  logic        resp_none_i,
    input  logic [31:0] resp_status_i,
    output logic        crc_err_o,
    output logic        frame_err_o,
    output logic        resp_drop_o,
    output logic        busy_o
`ifdef SDCARD_CMD_RESP_CRC_INJECT_EN
    ,
    input  logic        crc_inject_i
`endif
);

    localparam int unsigned CntMax = (NCR > RESP_TIMEOUT) ? NCR : RESP_TIMEOUT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    resp_state_e         state_q, state_d;
    logic [FrameW-1:0]   sh_q, sh_d;
    logic [5:0]          bit_q, bit_d;
    logic [CntW-1:0]     gap_q, gap_d;
    logic [5:0]          idx_q, idx_d;
    logic [31:0]         arg_q, arg_d;
    logic                out_q, out_d, oe_q, oe_d, inject_q, inject_d;
    logic                inject_req, frame_bad, crc_bad, ncr_done, app_timeout, accept;
    logic                crc_clear, crc_enable, crc_shift, crc_data;
    logic [CrcW-1:0]     crc;

`ifdef SDCARD_CMD_RESP_CRC_INJECT_EN
    assign inject_req = crc_inject_i;
`else
    assign inject_req = 1'b0;
`endif

    assign frame_bad   = !sh_q[46] || !sh_q[0];
    assign crc_bad     = sh_q[7:1] != crc;
    assign ncr_done    = gap_q >= CntW'(NCR);
    assign app_timeout = gap_q >= CntW'(RESP_TIMEOUT);
    assign accept      = (state_q == StWaitApp) && !resp_none_i && resp_valid_i;

    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i) begin
            state_q <= StRxIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRxIdle:    if (bit_en_i && !cmd_in_i) state_d = StRxShift;
            StRxShift:   if (bit_en_i && bit_q == 6'd0) state_d = StRxCheck;
            StRxCheck:   state_d = (frame_bad || crc_bad) ? StRxIdle : StWaitApp;
            StWaitApp: begin
                if (resp_none_i)       state_d = StRxIdle;
                else if (resp_valid_i) state_d = StNcrWait;
                else if (app_timeout)  state_d = StRxIdle;
            end
            StNcrWait:   if (bit_en_i && ncr_done) state_d = StTxShift;
            StTxShift:   if (bit_en_i && bit_q == 6'd0) state_d = StTxRelease;
            StTxRelease: if (bit_en_i) state_d = StRxIdle;
            default:     state_d = StRxIdle;
        endcase
    end

    always_comb begin
        busy_o      = state_q != StRxIdle;
        frame_err_o = (state_q == StRxCheck) && frame_bad;
        crc_err_o   = (state_q == StRxCheck) && !frame_bad && crc_bad;
        cmd_valid_o = (state_q == StRxCheck) && !frame_bad && !crc_bad;
        resp_drop_o = (state_q == StWaitApp) && !resp_none_i && !resp_valid_i && app_timeout;
        // Present the fresh fields alongside the valid pulse; they are captured at its end.
        cmd_index_o = cmd_valid_o ? sh_q[45:40] : idx_q;
        cmd_arg_o   = cmd_valid_o ? sh_q[39:8]  : arg_q;
        cmd_out_o   = out_q;
        cmd_oe_o    = oe_q;
    end

    always_comb begin
        sh_d       = sh_q;
        bit_d      = bit_q;
        gap_d      = gap_q;
        idx_d      = idx_q;
        arg_d      = arg_q;
        out_d      = out_q;
        oe_d       = oe_q;
        inject_d   = inject_q;
        crc_clear  = 1'b0;
        crc_enable = 1'b0;
        crc_shift  = 1'b0;
        crc_data   = sh_q[FrameW-1];
        if ((state_q == StRxCheck || state_q == StWaitApp || state_q == StNcrWait) &&
            bit_en_i && gap_q != CntW'(CntMax)) begin
            gap_d = gap_q + 1'b1;
        end
        case (state_q)
            StRxIdle: begin
                // Start bit is 0 and CRC init is 0, so a cleared CRC already covers it.
                crc_clear = 1'b1;
                if (bit_en_i && !cmd_in_i) begin
                    sh_d  = '0;
                    bit_d = 6'd46;
                end
            end
            StRxShift: begin
                if (bit_en_i) begin
                    sh_d       = {sh_q[FrameW-2:0], cmd_in_i};
                    bit_d      = bit_q - 6'd1;
                    crc_enable = bit_q >= 6'd8;
                    crc_data   = cmd_in_i;
                    if (bit_q == 6'd0) gap_d = '0;
                end
            end
            StRxCheck: begin
                if (!frame_bad && !crc_bad) begin
                    idx_d = sh_q[45:40];
                    arg_d = sh_q[39:8];
                end
            end
            StWaitApp: begin
                if (accept) begin
                    sh_d      = {2'b00, idx_q, resp_status_i, 8'h00};
                    crc_clear = 1'b1;
                    inject_d  = inject_req;
                end
            end
            StNcrWait: begin
                if (bit_en_i && ncr_done) begin
                    out_d      = sh_q[FrameW-1];
                    oe_d       = 1'b1;
                    sh_d       = {sh_q[FrameW-2:0], 1'b0};
                    bit_d      = 6'd46;
                    crc_enable = 1'b1;
                end
            end
            StTxShift: begin
                if (bit_en_i) begin
                    bit_d = bit_q - 6'd1;
                    if (bit_q >= 6'd8) begin
                        out_d      = sh_q[FrameW-1];
                        sh_d       = {sh_q[FrameW-2:0], 1'b0};
                        crc_enable = 1'b1;
                    end else if (bit_q != 6'd0) begin
                        out_d      = crc[CrcW-1] ^ (inject_q && bit_q == 6'd1);
                        crc_enable = 1'b1;
                        crc_shift  = 1'b1;
                    end else begin
                        out_d = 1'b1;
                    end
                end
            end
            StTxRelease: begin
                if (bit_en_i) begin
                    oe_d  = 1'b0;
                    out_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i) begin
            sh_q     <= '0;
            bit_q    <= '0;
            gap_q    <= '0;
            idx_q    <= '0;
            arg_q    <= '0;
            out_q    <= 1'b1;
            oe_q     <= 1'b0;
            inject_q <= 1'b0;
        end else begin
            sh_q     <= sh_d;
            bit_q    <= bit_d;
            gap_q    <= gap_d;
            idx_q    <= idx_d;
            arg_q    <= arg_d;
            out_q    <= out_d;
            oe_q     <= oe_d;
            inject_q <= inject_d;
        end
    end

    sdcard_crc7_serial u_crc7 (
        .PCLK_i    (PCLK_i),
        .PRESETn_i (PRESETn_i),
        .clear_i   (crc_clear),
        .enable_i  (crc_enable),
        .shift_i   (crc_shift),
        .data_i    (crc_data),
        .crc_o     (crc)
    );

endmodule

// File: tb/tb_sdcard_cmd_responder.sv
// Scoreboard bench for sdcard_cmd_responder: random host frames, reference model in the bench.
module tb_sdcard_cmd_responder;
    import sdcard_pkg::*;

    localparam int unsigned NcrP = 2;
    localparam int unsigned RtP  = 20;
    localparam int KValid = 0, KCrc = 1, KFrame = 2, KDrop = 3, KResp = 4;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        bit_en = 1'b0;
    logic        cmd_in = 1'b1;
    logic        resp_valid = 1'b0;
    logic        resp_none = 1'b0;
    logic [31:0] resp_status = '0;
    logic        cmd_out_o, cmd_oe_o, cmd_valid_o, crc_err_o, frame_err_o, resp_drop_o, busy_o;
    logic [5:0]  cmd_index_o;
    logic [31:0] cmd_arg_o;
`ifdef SDCARD_CMD_RESP_CRC_INJECT_EN
    logic        crc_inject = 1'b0;
`endif

    typedef struct {
        int          kind;
        longint      cyc;
        logic [47:0] data;
    } exp_t;

    exp_t        sb[$];
    longint      cyc = 0;
    int          div = 1;
    int          n_vec = 0;
    int          n_bad = 0;
    logic [5:0]  last_idx = '0;
    logic [31:0] last_arg = '0;

    always #5 PCLK = ~PCLK;

    sdcard_cmd_responder #(
        .NCR          (NcrP),
        .RESP_TIMEOUT (RtP)
    ) dut (
        .PCLK_i        (PCLK),
        .PRESETn_i     (PRESETn),
        .bit_en_i      (bit_en),
        .cmd_in_i      (cmd_in),
        .cmd_out_o     (cmd_out_o),
        .cmd_oe_o      (cmd_oe_o),
        .cmd_valid_o   (cmd_valid_o),
        .cmd_index_o   (cmd_index_o),
        .cmd_arg_o     (cmd_arg_o),
        .resp_valid_i  (resp_valid),
        .resp_none_i   (resp_none),
        .resp_status_i (resp_status),
        .crc_err_o     (crc_err_o),
        .frame_err_o   (frame_err_o),
        .resp_drop_o   (resp_drop_o),
        .busy_o        (busy_o)
`ifdef SDCARD_CMD_RESP_CRC_INJECT_EN
        ,
        .crc_inject_i  (crc_inject)
`endif
    );

    // CRC7 as the remainder of polynomial long division by x^7+x^3+1.
    function automatic logic [6:0] ref_crc7(input logic [39:0] body);
        logic [46:0] r;
        r = {body, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic logic [47:0] host_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] body;
        body = {2'b01, idx, arg};
        return {body, ref_crc7(body), 1'b1};
    endfunction

    function automatic logic [47:0] resp_frame(input logic [5:0] idx, input logic [31:0] st);
        logic [39:0] body;
        body = {2'b00, idx, st};
        return {body, ref_crc7(body), 1'b1};
    endfunction

    // Cycle of the n-th strobe strictly after cycle c (strobes fall on cyc % div == 0).
    function automatic longint nth_after(input longint c, input int n);
        return ((c / longint'(div)) + 1) * longint'(div) + longint'(n - 1) * longint'(div);
    endfunction

    function automatic longint max2(input longint a, input longint b);
        return (a > b) ? a : b;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input longint c, input logic [47:0] data);
        exp_t e;
        e.kind = kind;
        e.cyc  = c;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic pop_check(input int kind, input logic [47:0] data, input longint c);
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d data %0h at cycle %0d, expected none",
                     kind, data, c);
        end else begin
            e = sb.pop_front();
            check("event_kind", 64'(kind), 64'(e.kind));
            check("event_cycle", 64'(c), 64'(e.cyc));
            check("event_data", 64'(data), 64'(e.data));
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
        cyc++;
        bit_en     = (cyc % longint'(div)) == 0;
        cmd_in     = 1'b1;
        resp_valid = 1'b0;
        resp_none  = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] f, output longint t_end);
        for (int i = 47; i >= 0; i--) begin
            do tick(); while (!bit_en);
            cmd_in = f[i];
        end
        t_end = cyc;
    endtask

    // mode: 0 respond, 1 no response, 2 bad CRC, 3 frame error, 4 timeout, 5 reset mid-response
    task automatic run_txn(input int mode, input logic [5:0] idx, input logic [31:0] arg,
                           input logic [31:0] st, input int dly, input int sel);
        logic [47:0] f;
        longint      t, acc, s, w;
        f = host_frame(idx, arg);
        if (mode == 2) f[7:1] = f[7:1] ^ 7'(sel);
        if (mode == 3) begin
            if (sel[0]) f[0] = 1'b0;
            else        f[46] = 1'b0;
        end
        send_frame(f, t);
        if (mode == 2)      push(KCrc, t + 1, '0);
        else if (mode == 3) push(KFrame, t + 1, '0);
        else begin
            push(KValid, t + 1, {10'b0, idx, arg});
            last_idx = idx;
            last_arg = arg;
        end
        if (mode == 0 || mode == 5) begin
            repeat (dly) tick();
            resp_valid  = 1'b1;
            resp_status = st;
            acc = cyc;
            s = max2(nth_after(t, NcrP + 1), nth_after(acc, 1));
            if (mode == 0) begin
                push(KResp, s + 1, resp_frame(idx, st));
                while (cyc < s + 48 * longint'(div)) tick();
            end else begin
                while (cyc < s + 10 * longint'(div)) tick();
                tick();
                PRESETn = 1'b0;
                #1;
                check("rst_mid_oe", 64'(cmd_oe_o), 64'd0);
                check("rst_mid_out", 64'(cmd_out_o), 64'd1);
                check("rst_mid_busy", 64'(busy_o), 64'd0);
                repeat (2) tick();
                PRESETn = 1'b1;
                last_idx = '0;
                last_arg = '0;
                check("rst_mid_index", 64'(cmd_index_o), 64'd0);
            end
        end else if (mode == 4) begin
            w = nth_after(t, RtP) + 1;
            push(KDrop, w, '0);
            while (cyc <= w) tick();
            check("drop_idle", 64'(busy_o), 64'd0);
        end else begin
            if (mode == 1) begin
                repeat (dly) tick();
                resp_none   = 1'b1;
                resp_valid  = sel[0];
                resp_status = st;
            end
            w = nth_after(t, NcrP + 2) + 1;
            while (cyc < w) tick();
            check("no_drive_oe", 64'(cmd_oe_o), 64'd0);
            check("no_drive_busy", 64'(busy_o), 64'd0);
            check("index_held", 64'(cmd_index_o), 64'(last_idx));
            check("arg_held", 64'(cmd_arg_o), 64'(last_arg));
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    initial begin
        logic        prev_oe;
        logic        rel_pend;
        int          cap_cnt;
        logic [47:0] cap;
        longint      start_c;
        prev_oe = 1'b0; rel_pend = 1'b0; cap_cnt = 0; cap = '0; start_c = 0;
        forever begin
            @(negedge PCLK);
            if (!PRESETn) begin
                prev_oe  = 1'b0;
                rel_pend = 1'b0;
                cap_cnt  = 0;
            end else begin
                if (cmd_valid_o) pop_check(KValid, {10'b0, cmd_index_o, cmd_arg_o}, cyc);
                if (crc_err_o)   pop_check(KCrc, '0, cyc);
                if (frame_err_o) pop_check(KFrame, '0, cyc);
                if (resp_drop_o) pop_check(KDrop, '0, cyc);
                if (cmd_oe_o && !prev_oe) begin
                    start_c = cyc;
                    cap_cnt = 0;
                end
                if (bit_en && cmd_oe_o && cap_cnt < 48) begin
                    cap = {cap[46:0], cmd_out_o};
                    cap_cnt++;
                    if (cap_cnt == 48) begin
                        pop_check(KResp, cap, start_c);
                        rel_pend = 1'b1;
                    end
                end else if (bit_en && rel_pend) begin
                    check("release_oe", 64'(cmd_oe_o), 64'd0);
                    rel_pend = 1'b0;
                    cap_cnt  = 0;
                end
                prev_oe = cmd_oe_o;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] body;
        int          r;
        repeat (3) tick();
        check("rst_out", 64'(cmd_out_o), 64'd1);
        check("rst_oe", 64'(cmd_oe_o), 64'd0);
        check("rst_index", 64'(cmd_index_o), 64'd0);
        check("rst_arg", 64'(cmd_arg_o), 64'd0);
        check("rst_pulses", 64'({cmd_valid_o, crc_err_o, frame_err_o, resp_drop_o}), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        PRESETn = 1'b1;
        tick();

        check("pkg_crc7_cmd0", 64'(crc7(40'h40_0000_0000)), 64'h4A);
        check("pkg_crc7_cmd8", 64'(crc7(40'h48_0000_01AA)), 64'h43);
        for (int i = 0; i < 4; i++) begin
            body = {8'($urandom), $urandom};
            check("pkg_crc7_rand", 64'(crc7(body)), 64'(ref_crc7(body)));
        end

        div = 1;
        run_txn(1, 6'd0, 32'h0, 32'h0, 2, 0);
        run_txn(0, 6'd8, 32'h0000_01AA, 32'h0000_01AA, 2, 0);
        run_txn(2, 6'd17, 32'h0, 32'h0, 2, 1);
        run_txn(3, 6'd17, 32'h0, 32'h0, 2, 0);
        run_txn(4, 6'd17, 32'h0000_1234, 32'h0, 2, 0);
        run_txn(1, 6'd55, 32'hDEAD_BEEF, 32'h1, 3, 1);
        run_txn(5, 6'd8, 32'h0000_01AA, 32'h0000_01AA, 2, 0);
        run_txn(1, 6'd0, 32'h0, 32'h0, 2, 0);

        for (int n = 0; n < 40; n++) begin
            div = int'($urandom_range(1, 3));
            r = int'($urandom_range(0, 9));
            run_txn((r <= 4 || r == 9) ? 0 : (r - 4), 6'($urandom), $urandom, $urandom,
                    int'($urandom_range(2, 8)), int'($urandom_range(1, 127)));
        end

        repeat (20) tick();
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sdcard_cmd_responder.md
# sdcard_cmd_responder

Card-side SD command-line responder; the counterpart of the host command engine. It samples 48-bit host command frames on the CMD line and checks framing and CRC7. It then hands the command index and argument to the card application logic and drives the 48-bit response frame back after the NCR gap. It serves as the card model in controller benches and as the CMD front end of a device-side SD core.

## Interface
Parameters:
- NCR, default 2: minimum bit periods between the command end bit and the response start bit. Legal range 2..64.
- RESP_TIMEOUT, default 64: bit periods allowed for the application to answer before the command is dropped.

Ports:
- PCLK_i  in  1  block clock.
- PRESETn_i  in  1  reset. Asynchronous, active-low.
- bit_en_i  in  1  one-PCLK strobe per SD bit period. All line sampling and driving happens only on this strobe.
- cmd_in_i  in  1  sampled CMD line.
- cmd_out_o  out  1  CMD drive value.
- cmd_oe_o  out  1  CMD output enable.
- cmd_valid_o  out  1  one-cycle pulse: a good command was received.
- cmd_index_o  out  6  received index. Held until the next good command.
- cmd_arg_o  out  32  received argument. Held until the next good command.
- resp_valid_i  in  1  the application supplies a response.
- resp_none_i  in  1  the command takes no response (e.g. CMD0).
- resp_status_i  in  32  response payload (card status / R7 / OCR).
- crc_err_o  out  1  one-cycle pulse: command CRC7 mismatch.
- frame_err_o  out  1  one-cycle pulse: transmission bit ≠ 1 or end bit ≠ 1.
- resp_drop_o  out  1  one-cycle pulse: application timeout.
- busy_o  out  1  high in any state other than RX_IDLE.
- crc_inject_i  in  1  CRC corruption request. Present only with the configuration macro.

## Operation
- Reset values: cmd_out_o=1, cmd_oe_o=0, cmd_index_o=0, cmd_arg_o=0, every pulse output=0, busy_o=0, state RX_IDLE.
- CRC7 uses polynomial x^7+x^3+1 (0x09) with init 0. It covers frame bits 47:8 (start bit, transmission bit, index, argument/status) and is compared with bits 7:1.
- States and transitions:
  - RX_IDLE: a strobe with cmd_in_i=0 captures bit 47 → RX_SHIFT.
  - RX_SHIFT: shifts one bit per strobe, MSB first. After bit 0 (the end bit) → RX_CHECK.
  - RX_CHECK: one PCLK cycle, not gated by bit_en_i. The first matching row wins:
    - frame error → frame_err_o, RX_IDLE.
    - CRC mismatch → crc_err_o, RX_IDLE.
    - otherwise → update index/argument, cmd_valid_o, WAIT_APP.
  - WAIT_APP: exits on the first matching row:
    - resp_none_i → RX_IDLE.
    - resp_valid_i → latch {0,0,index,resp_status_i}, → NCR_WAIT.
    - RESP_TIMEOUT strobes counted since the end bit → resp_drop_o, RX_IDLE.
    - If resp_none_i and resp_valid_i are high together, resp_none_i wins.
  - NCR_WAIT: line released until at least NCR strobes have elapsed since the end bit → TX_SHIFT.
  - TX_SHIFT: drives 48 bits with oe=1. Bits 7:1 carry the CRC7 computed serially during transmission; bit 0 = 1.
  - TX_RELEASE: on the next strobe oe=0 → RX_IDLE.
- Strobe counting (NCR and timeout) begins with the first strobe after the end-bit strobe.
- resp_valid_i and resp_none_i are ignored outside WAIT_APP.
- cmd_in_i is ignored from RX_CHECK through TX_RELEASE; collision detection is not performed.
- Asserting reset mid-frame releases the line immediately and discards the partial frame.

## Timing
- End bit sampled on strobe T (PCLK cycle c) → cmd_valid_o, crc_err_o or frame_err_o high in cycle c+1 only.
- Response start bit: driven on the (NCR+1)-th strobe after T, or on the first strobe after resp_valid_i is accepted, whichever is later.
- cmd_out_o and cmd_oe_o are registered and change only on strobes.
- The response occupies exactly 48 strobes, followed by one release strobe.
- A back-to-back host frame is accepted from the strobe following the release strobe.

## Configuration
- SDCARD_CMD_RESP_CRC_INJECT_EN defined: the crc_inject_i port exists. When crc_inject_i is sampled high at response latch, bit 1 of the transmitted response CRC is inverted; used to exercise the host engine's CRC-error path.
- Undefined: the port is absent and the CRC is always correct.

## Structure
- sdcard_pkg holds:
  - CRC7 polynomial constant.
  - frame width constants (48, 40, 7).
  - responder state enum.
  - the shared crc7 function used by benches.
- One sub-module, sdcard_crc7_serial: clear/shift/enable inputs, 7-bit result. It is reused for RX checking and TX generation.

## Test plan
- Host frame 0x40_0000_0000_95 (CMD0), NCR=2, resp_none_i pulsed → cmd_valid_o with index 0, arg 0; cmd_oe_o stays 0; back to idle.
- Frame 0x48_0000_01AA_87 (CMD8), resp_valid_i with status 0x000001AA → response starts on the 3rd strobe after the end bit. Response bits 47:8 = 0x08_0000_01AA, CRC matches the package function, end bit = 1.
- Frame 0x51_0000_0000_57 (bad CRC; correct value 0x55) → crc_err_o pulse, no cmd_valid_o, line never driven.
- Frame with transmission bit 0 (0x11_0000_0000_xx) → frame_err_o pulse.
- Valid CMD17 with no application answer → resp_drop_o exactly RESP_TIMEOUT strobes after the end bit.
- Reset asserted mid-response → cmd_oe_o=0 the same cycle; next CMD0 frame accepted normally.
